// File: rtl/seg_scan_counter.sv
// Multi-digit BCD/hex up/down counter with prescaled tick, synchronous load,
// and a time-multiplexed 7-segment driver with one-hot digit select.
module seg_scan_counter #(
  parameter int DIGITS         = 4,
  parameter int PRESCALE       = 50000000,
  parameter int REFRESH_DIV    = 50000,
  parameter bit BCD            = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic                  wrap,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     sel
);

  localparam int PW = $clog2(PRESCALE);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);

  localparam logic [PW-1:0] PRESC_LAST  = PW'(PRESCALE - 1);
  localparam logic [RW-1:0] REFR_LAST   = RW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST    = IW'(DIGITS - 1);
  localparam logic [3:0]    NIB_MAX     = BCD ? 4'd9 : 4'd15;
  localparam logic [6:0]    SEG_ZERO    = SEG_ACTIVE_LOW ? ~7'h3F : 7'h3F;

  logic [PW-1:0]         presc;
  logic [RW-1:0]         refr;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   count_next;
  logic                  carry;
  logic [3:0]            nib;
  logic [3:0]            digit_nib;

  function automatic logic [6:0] encode(input logic [3:0] v);
    logic [6:0] e;
    case (v)
      4'h0: e = 7'h3F;
      4'h1: e = 7'h06;
      4'h2: e = 7'h5B;
      4'h3: e = 7'h4F;
      4'h4: e = 7'h66;
      4'h5: e = 7'h6D;
      4'h6: e = 7'h7D;
      4'h7: e = 7'h07;
      4'h8: e = 7'h7F;
      4'h9: e = 7'h6F;
      4'hA: e = 7'h77;
      4'hB: e = 7'h7C;
      4'hC: e = 7'h39;
      4'hD: e = 7'h5E;
      4'hE: e = 7'h79;
      default: e = 7'h71;
    endcase
    // Out-of-range BCD digits (only reachable by load) show as F.
    if (BCD && v > 4'd9) e = 7'h71;
    return SEG_ACTIVE_LOW ? ~e : e;
  endfunction

  // Ripple carry/borrow through the nibbles; an illegal BCD nibble behaves as 9.
  always_comb begin
    count_next = count;
    carry      = 1'b1;
    nib        = '0;
    for (int i = 0; i < DIGITS; i++) begin
      nib = count[4*i +: 4];
      if (carry) begin
        if (up) begin
          if (nib >= NIB_MAX) begin
            nib = 4'd0;
          end else begin
            nib   = nib + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (nib == 4'd0) begin
            nib = NIB_MAX;
          end else if (nib > NIB_MAX) begin
            nib   = NIB_MAX - 4'd1;
            carry = 1'b0;
          end else begin
            nib   = nib - 4'd1;
            carry = 1'b0;
          end
        end
      end
      count_next[4*i +: 4] = nib;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      count <= '0;
      presc <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      if (load) begin
        count <= load_value;
        presc <= '0;
      end else if (en) begin
        if (presc == PRESC_LAST) begin
          presc <= '0;
          count <= count_next;
          tick  <= 1'b1;
          wrap  <= carry;
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

  always_comb begin
    digit_nib = count[3:0];
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) digit_nib = count[4*i +: 4];
    end
  end

  // The scan runs regardless of en/load so the display never stalls.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      refr <= '0;
      idx  <= '0;
      sel  <= DIGITS'(1);
      seg  <= SEG_ZERO;
    end else begin
      sel <= DIGITS'(1) << idx;
      seg <= encode(digit_nib);
      if (refr == REFR_LAST) begin
        refr <= '0;
        idx  <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
        refr <= refr + RW'(1);
      end
    end
  end

endmodule

// File: doc/seg_scan_counter.md
Name: seg_scan_counter

Overview:
Parametrised successor to the board's free-running counter/display logic. Holds a DIGITS-nibble up/down counter (BCD or hex), advanced by an internal prescaler tick, with synchronous load. Drives one shared 7-segment bus plus a one-hot digit select, time-multiplexed at a programmable refresh rate, for external multi-digit displays on GPIO.

Parameters:
DIGITS, 4, number of nibbles in the counter and number of multiplexed digits (2..8).
PRESCALE, 50000000, CLOCK_50 cycles per count tick (>=2).
REFRESH_DIV, 50000, CLOCK_50 cycles each digit stays selected (>=2).
BCD, 1, 1 = each nibble counts 0..9 with decimal carry; 0 = 0..F hex.
SEG_ACTIVE_LOW, 1, 1 = seg output inverted (lit segment = 0).

Ports:
CLOCK_50  in  1  system clock; all state on rising edge.
reset  in  1  asynchronous, active-high reset.
en  in  1  1 = prescaler runs and counter may tick; 0 = counter and prescaler frozen.
up  in  1  1 = count up, 0 = count down; sampled on the tick cycle.
load  in  1  synchronous load strobe.
load_value  in  4*DIGITS  value loaded on load; nibble 0 = least significant digit.
count  out  4*DIGITS  current counter value.
tick  out  1  one-cycle pulse when the counter steps.
wrap  out  1  one-cycle pulse coincident with tick when the counter wraps (max->0 or 0->max).
seg  out  7  segment bus {g,f,e,d,c,b,a} for the selected digit.
sel  out  DIGITS  one-hot digit select, active-high; bit i = digit i.

Behaviour:
- Reset (async, active-high): count=0, prescaler=0, refresh counter=0, digit index=0, tick=0, wrap=0, sel=1 (digit 0), seg=encode(0) = 7'h40 active-low / 7'h3F active-high.
- Prescaler: counts 0..PRESCALE-1 only while en=1; holds value when en=0. Step condition: en=1 and prescaler=PRESCALE-1; prescaler then returns to 0.
- tick and wrap are registered: asserted the cycle after the step condition, together with the new count value.
- Counter step (up): nibble 0 +1; nibble reaching 9 (BCD) or F (hex) becomes 0 and carries to the next nibble. Down: nibble 0 -1; nibble at 0 becomes 9/F and borrows.
- wrap=1 when an up step leaves all nibbles at max (all 9 / all F) and returns to all 0, or when a down step from all 0 goes to all max.
- BCD illegal nibble (A..F, only possible via load): treated as 9 on the next step (up -> 0 with carry, down -> 8).
- load=1: count<=load_value and prescaler<=0 on the next edge, regardless of en. tick=0 and wrap=0 that cycle. load has priority over a simultaneous step; the step is discarded.
- Scan: refresh counter runs continuously (independent of en and load), 0..REFRESH_DIV-1. At terminal value the digit index advances (DIGITS-1 -> 0).
- sel and seg registered together each cycle: sel=onehot(index); seg=encode(count nibble[index]), inverted when SEG_ACTIVE_LOW=1. One-cycle latency from count or index change to seg/sel; sel is never zero and never multi-hot.
- Encode (active-high, {g..a}): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71 (hex). In BCD mode illegal nibbles display as F (7'h71) without modifying count.
- Each digit is selected for exactly REFRESH_DIV cycles; full scan period is DIGITS*REFRESH_DIV cycles.

Test Plan:
- Reset: DIGITS=4, PRESCALE=4, REFRESH_DIV=3, BCD=1; assert reset mid-count -> count=0000, sel=0001, seg=7'h40, tick=0 immediately, without a clock edge.
- BCD up wrap: load 0x9998, en=1, up=1 -> after 4 cycles count=9999 tick=1 wrap=0; after 4 more count=0000 tick=1 wrap=1.
- Hex down borrow: BCD=0, load 0x0100, up=0 -> next tick count=0x00FF; load 0x0000 -> next tick count=0xFFFF wrap=1.
- en and load priority: en=0 for 20 cycles -> count constant, no tick; load 0x1234 on the same cycle as a step -> count=0x1234, tick=0, next tick after 4 cycles -> 0x1235.
- Scan: count=0x4321 held -> sel sequence 0001,0010,0100,1000,0001 each 3 cycles; seg = active-low encode of 1,2,3,4 (7'h79,7'h24,7'h30,7'h19) aligned with sel.
- Illegal BCD: load 0x000C -> seg for digit 0 = 7'h0E (active-low F); next up tick -> count=0x0010.
